ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_sram_bytemask.sv | 21 ++
 rtl/ahb_sram_slave.sv | 121 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite shared codes, slave FSM states and address-phase bundle.
// Optional macro AHB_SLV_ERR_EN (see ahb_sram_slave) enables ERROR responses.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef struct packed {
    logic       write;
    logic       ill;
    logic [3:0] be;
  } aph_t;

endpackage

// File: rtl/ahb_sram_bytemask.sv
// Little-endian byte-lane enable from HSIZE and HADDR[1:0].
// Unsupported sizes yield no lanes.
module ahb_sram_bytemask
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      hsize == HSIZE_BYTE: be = 4'b0001 << addr;
      hsize == HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      hsize == HSIZE_WORD: be = 4'b1111;
      default:             be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states.
// Define AHB_SLV_ERR_EN for two-cycle ERROR on illegal transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HPROT,
  input  logic [2:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] WLAST =
    2'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [31:0]   mem [MEM_WORDS];
  state_t        state, state_d;
  logic [1:0]    cnt, cnt_d;
  aph_t          aph;
  logic [AW-1:0] idx;
  logic [3:0]    be_in;
  logic          active, illegal;
  logic          ready_st, take, wr_en;
  logic          unused;

  ahb_sram_bytemask u_mask (
    .hsize (HSIZE),
    .addr  (HADDR[1:0]),
    .be    (be_in)
  );

  assign unused = ^{HBURST, HPROT, HTRANS[2],
                    HADDR[31:AW+2]};

  always_comb begin
    active = 1'b0;
    unique case (HTRANS[1:0])
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
    endcase
  end

  assign illegal =
    (HSIZE > HSIZE_WORD) ||
    (HSIZE == HSIZE_HALF && HADDR[0]) ||
    (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

  // Only sample a new address phase while our data phase is completing.
  assign ready_st = state inside {ST_IDLE, ST_DATA, ST_ERR2};
  assign take = ready_st && HSEL && HREADYIN && active;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      ST_WAIT: begin
        if (cnt == WLAST) state_d = ST_DATA;
        else              cnt_d   = cnt + 2'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      cnt_d = 2'd0;
      if (ERR_EN && illegal)     state_d = ST_ERR1;
      else if (WAIT_STATES > 0)  state_d = ST_WAIT;
      else                       state_d = ST_DATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      aph   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (take) begin
        aph <= '{write: HWRITE, ill: illegal, be: be_in};
        idx <= HADDR[AW+1:2];
      end
    end
  end

  assign wr_en = (state == ST_DATA) && aph.write &&
                 !aph.ill && !HRST;

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (aph.be[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  assign HREADY = HRST || !(state inside {ST_WAIT, ST_ERR1});
  assign HRESP  = (!HRST && state inside {ST_ERR1, ST_ERR2})
                  ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = (!HRST && state == ST_DATA &&
                   !aph.write && !aph.ill) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: zero-wait and two-wait slaves on one bus.
// Expectations come from a word-array model of the AHB rules.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        HCLK, HRST;
  logic        hsel0, hsel2;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST, HPROT, HTRANS;
  logic        hreadyin;
  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2, resp0, resp2;

  int          cur;
  logic [31:0] rd_v;
  logic        rdy_v, rsp_v;
  int          n_chk, n_fail;
  logic [31:0] mdl [2][16];

  logic [31:0] rd;
  int          nw;
  logic        rw, rf;

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRST(HRST), .HSEL(hsel0), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADYIN(hreadyin), .HRDATA(rdata0), .HREADY(ready0),
    .HRESP(resp0)
  );

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRST(HRST), .HSEL(hsel2), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADYIN(hreadyin), .HRDATA(rdata2), .HREADY(ready2),
    .HRESP(resp2)
  );

  assign hreadyin = (cur == 2) ? ready2 : ready0;
  assign rdy_v    = (cur == 2) ? ready2 : ready0;
  assign rsp_v    = (cur == 2) ? resp2  : resp0;
  assign rd_v     = (cur == 2) ? rdata2 : rdata0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic bit legal(logic [31:0] a, logic [2:0] sz);
    return sz <= 3'd2 && (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  function automatic void mwrite(int d, logic [31:0] a,
                                 logic [2:0] sz, logic [31:0] wd);
    int w  = widx(a);
    int lo = int'(a % 4);
    for (int k = 0; k < (1 << sz); k++)
      mdl[d][w][8*(lo+k) +: 8] = wd[8*(lo+k) +: 8];
  endfunction

  function automatic logic [31:0] raddr(logic [2:0] sz);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_FC00) |
        (32'($urandom_range(0, 15)) << 2);
    if (sz == 3'd0) a = a | 32'($urandom_range(0, 3));
    if (sz == 3'd1) a = a | (32'($urandom_range(0, 1)) << 1);
    return a;
  endfunction

  task automatic idle_bus();
    hsel0 = 1'b0; hsel2 = 1'b0;
    HTRANS = 3'd0; HWRITE = 1'b0;
  endtask

  // One isolated transfer; returns data, wait count and HRESP seen.
  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    hsel0 = (cur == 0); hsel2 = (cur == 2);
    HADDR = a; HWRITE = wr; HSIZE = sz;
    HTRANS = {1'($urandom), HTRANS_NONSEQ};
    HBURST = 3'($urandom); HPROT = 3'($urandom);
    @(posedge HCLK); #1;
    idle_bus();
    HADDR = $urandom; HSIZE = 3'($urandom); HWDATA = wd;
    nw = 0; rw = 1'b0; rf = 1'b0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
      if (rdy_v) begin
        rd = rd_v; rf = rsp_v;
        break;
      end
      nw++; rw = rw | rsp_v;
      @(posedge HCLK); #1;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    HRST = 1'b1; cur = 0; idle_bus();
    HADDR = '0; HSIZE = '0; HWDATA = '0;
    HBURST = '0; HPROT = '0;
    repeat (2) @(posedge HCLK);
    for (int p = 0; p < 2; p++) begin
      @(negedge HCLK);
      n_chk++;
      if ({ready0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset0[%0d] got %b %b %h want 1 0 0",
                 p, ready0, resp0, rdata0);
      end
      n_chk++;
      if ({ready2, resp2, rdata2} !== {1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset2[%0d] got %b %b %h want 1 0 0",
                 p, ready2, resp2, rdata2);
      end
      @(posedge HCLK); #1;
      HRST = 1'b0;
    end
  endtask

  // Random-op loop shared by init (word writes) and random tests.
  task automatic run_ops(input string tag, input int n,
                         input bit init);
    logic [31:0] a, wd, erd;
    logic [2:0]  sz;
    logic        wr, eerr;
    int          d, enw;
    d = (cur == 2) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      if (init) begin
        wr = 1'b1; sz = HSIZE_WORD;
        a = ($urandom & 32'hFFFF_FC00) | (32'(i) << 2);
      end else begin
        wr = 1'($urandom);
        if ($urandom_range(0, 4) == 0) begin
          sz = 3'($urandom_range(0, 7));
          a = raddr(3'd0);
        end else begin
          sz = 3'($urandom_range(0, 2));
          a = raddr(sz);
        end
      end
      wd = $urandom;
      eerr = ERR_EN && !legal(a, sz);
      enw  = eerr ? 1 : ((cur == 2) ? 2 : 0);
      erd  = (!wr && legal(a, sz)) ? mdl[d][widx(a)] : 32'h0;
      xfer(wr, a, sz, wd);
      n_chk++;
      if ({rd, nw, rw, rf} !== {erd, enw, eerr, eerr}) begin
        n_fail++;
        $display("FAIL %s[%0d] a=%h sz=%0d wr=%b got rd=%h w=%0d e=%b%b want rd=%h w=%0d e=%b%b",
                 tag, i, a, sz, wr, rd, nw, rw, rf,
                 erd, enw, eerr, eerr);
      end
      if (wr && legal(a, sz)) mwrite(d, a, sz, wd);
    end
  endtask

  task automatic test_basic();
    cur = 0;
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    mwrite(0, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    n_chk++;
    if ({nw, rf} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_wr got waits=%0d err=%b want 0 0", nw, rf);
    end
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    n_chk++;
    if ({rd, nw, rf} !== {32'hDEADBEEF, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_rd got %h w=%0d e=%b want deadbeef 0 0",
               rd, nw, rf);
    end
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
    xfer(1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000);
    mwrite(0, 32'h10, HSIZE_WORD, 32'h11223344);
    mwrite(0, 32'h13, HSIZE_BYTE, 32'hAA000000);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    n_chk++;
    if (rd !== 32'hAA223344) begin
      n_fail++;
      $display("FAIL byte_lane got %h want aa223344", rd);
    end
  endtask

  task automatic test_wait();
    cur = 2;
    xfer(1'b1, 32'h20, HSIZE_WORD, 32'hCAFEF00D);
    mwrite(1, 32'h20, HSIZE_WORD, 32'hCAFEF00D);
    xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0);
    n_chk++;
    if ({rd, nw, rw, rf} !== {32'hCAFEF00D, 32'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wait_rd got %h w=%0d e=%b%b want cafef00d 2 00",
               rd, nw, rw, rf);
    end
  endtask

  task automatic test_wrap();
    cur = 0;
    xfer(1'b1, 32'h400, HSIZE_WORD, 32'h5);
    mwrite(0, 32'h400, HSIZE_WORD, 32'h5);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0);
    n_chk++;
    if (rd !== 32'h5) begin
      n_fail++;
      $display("FAIL wrap got %h want 00000005", rd);
    end
  endtask

  task automatic test_illegal();
    int enw;
    for (int c = 0; c <= 2; c += 2) begin
      cur = c;
      enw = ERR_EN ? 1 : c;
      xfer(1'b1, 32'h0, HSIZE_WORD, 32'h12345678);
      mwrite(c / 2, 32'h0, HSIZE_WORD, 32'h12345678);
      xfer(1'b1, 32'h2, HSIZE_WORD, 32'hFFFFFFFF);
      n_chk++;
      if ({nw, rw, rf} !== {enw, ERR_EN, ERR_EN}) begin
        n_fail++;
        $display("FAIL ill_wr%0d got w=%0d e=%b%b want %0d %b%b",
                 c, nw, rw, rf, enw, ERR_EN, ERR_EN);
      end
      xfer(1'b0, 32'h5, HSIZE_HALF, 32'h0);
      n_chk++;
      if ({rd, nw, rf} !== {32'h0, enw, ERR_EN}) begin
        n_fail++;
        $display("FAIL ill_rd%0d got %h w=%0d e=%b want 0 %0d %b",
                 c, rd, nw, rf, enw, ERR_EN);
      end
      xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0);
      n_chk++;
      if (rd !== 32'h12345678) begin
        n_fail++;
        $display("FAIL ill_keep%0d got %h want 12345678", c, rd);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    cur = 2;
    xfer(1'b1, 32'h30, HSIZE_WORD, 32'h600DCAFE);
    mwrite(1, 32'h30, HSIZE_WORD, 32'h600DCAFE);
    hsel2 = 1'b1; HADDR = 32'h30; HWRITE = 1'b1;
    HSIZE = HSIZE_WORD; HTRANS = {1'b0, HTRANS_NONSEQ};
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = 32'h0BAD0BAD;
    @(negedge HCLK);
    n_chk++;
    if (ready2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_wait got ready=%b want 0", ready2);
    end
    HRST = 1'b1;
    @(posedge HCLK); #1;
    HRST = 1'b0;
    @(negedge HCLK);
    n_chk++;
    if ({ready2, resp2, rdata2} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstw_out got %b %b %h want 1 0 0",
               ready2, resp2, rdata2);
    end
    repeat (3) @(posedge HCLK);
    #1;
    xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0);
    n_chk++;
    if (rd !== 32'h600DCAFE) begin
      n_fail++;
      $display("FAIL rstw_keep got %h want 600dcafe", rd);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic        op_wr [N];
    logic [31:0] op_a  [N];
    logic [2:0]  op_sz [N];
    logic [31:0] op_wd [N];
    logic [31:0] ev;
    cur = 0;
    for (int i = 0; i < N; i++) begin
      op_wr[i] = 1'($urandom);
      op_sz[i] = 3'($urandom_range(0, 2));
      op_a[i]  = raddr(op_sz[i]);
      op_wd[i] = $urandom;
    end
    op_wr[0] = 1'b1; op_sz[0] = HSIZE_WORD; op_a[0] = 32'h0C;
    op_wr[1] = 1'b0; op_sz[1] = HSIZE_WORD; op_a[1] = 32'h0C;
    op_wr[2] = 1'b1; op_sz[2] = HSIZE_BYTE; op_a[2] = 32'h0E;
    op_wr[3] = 1'b0; op_sz[3] = HSIZE_BYTE; op_a[3] = 32'h0D;
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        hsel0 = 1'b1; HADDR = op_a[i];
        HWRITE = op_wr[i]; HSIZE = op_sz[i];
        HTRANS = {1'b0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ};
      end else begin
        idle_bus();
      end
      if (i > 0) HWDATA = op_wd[i-1];
      @(negedge HCLK);
      if (i > 0) begin
        ev = mdl[0][widx(op_a[i-1])];
        n_chk++;
        if ({ready0, resp0} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_rdy[%0d] got %b %b want 1 0",
                   i - 1, ready0, resp0);
        end
        if (!op_wr[i-1]) begin
          n_chk++;
          if (rdata0 !== ev) begin
            n_fail++;
            $display("FAIL b2b_rd[%0d] got %h want %h",
                     i - 1, rdata0, ev);
          end
        end else begin
          mwrite(0, op_a[i-1], op_sz[i-1], op_wd[i-1]);
        end
      end
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    cur = 0; run_ops("init0", 16, 1'b1);
    cur = 2; run_ops("init2", 16, 1'b1);
    test_basic();
    test_wait();
    test_wrap();
    test_illegal();
    test_reset_mid_wait();
    test_back_to_back();
    cur = 0; run_ops("rand0", 25, 1'b0);
    cur = 2; run_ops("rand2", 25, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
